// File: rtl/seq_rec_readout.sv
// Reads a sequence recorder over its slave bus and pushes the bytes as packed 32-bit words into a FIFO.
// Latency: one cycle from START to the first bus strobe; each word is pushed the cycle after its last byte returns.
// Backpressure: FIFO_FULL holds the finished word in place and blocks new reads until the word has been pushed.
module seq_rec_readout #(
  parameter int ABUSWIDTH     = 16,
  parameter int REC_BASEADDR  = 0,
  parameter int MEM_BYTES     = 8192,
  parameter int POLL_INTERVAL = 16,
  parameter int POLL_TIMEOUT  = 65535
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 START_REC,
  input  logic [15:0]          BYTE_COUNT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [15:0]          WORD_CNT,
  output logic [ABUSWIDTH-1:0] M_ADD,
  output logic                 M_RD,
  output logic                 M_WR,
  output logic [7:0]           M_DATA_OUT,
  input  logic [7:0]           M_DATA_IN,
  input  logic                 FIFO_FULL,
  output logic                 FIFO_WRITE,
  output logic [31:0]          FIFO_DATA
);

  // Recorder register map: control/status byte at base+1, memory from base+16.
  localparam logic [ABUSWIDTH-1:0] LP_BASE     = ABUSWIDTH'(REC_BASEADDR);
  localparam logic [ABUSWIDTH-1:0] LP_STAT_ADD = LP_BASE + ABUSWIDTH'(1);
  localparam logic [ABUSWIDTH-1:0] LP_MEM_ADD  = LP_BASE + ABUSWIDTH'(16);
  localparam logic [15:0]          LP_WAIT_LD  = 16'(POLL_INTERVAL - 1);
  localparam logic [16:0]          LP_TMO      = 17'(POLL_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_POLL,
    ST_POLL_CHK,
    ST_WAIT,
    ST_READ,
    ST_FLUSH
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [15:0]            r_word_cnt;
  logic [ABUSWIDTH-1:0]   r_m_add;
  logic                   r_m_rd;
  logic                   r_m_wr;
  logic [31:0]            r_fifo_dat;
  logic [31:0]            r_asm;       // word under assembly
  logic                   r_word_rdy;  // r_fifo_dat holds a finished word not yet pushed
  logic [15:0]            r_n;         // clamped byte count for this run
  logic [15:0]            r_iss;       // bytes whose read has been issued
  logic [15:0]            r_rcv;       // bytes whose data has been captured
  logic                   r_inflt;     // a memory read issued last cycle returns data now
  logic [15:0]            r_poll_cnt;
  logic [15:0]            r_wait;

  logic [15:0]            w_n_clamp;
  logic [1:0]             w_bus_lane;
  logic                   w_cap_done;
  logic                   w_push;
  logic                   w_iss_ok;
  logic [31:0]            w_asm_nx;

  assign w_n_clamp  = ({16'd0, BYTE_COUNT} > 32'(MEM_BYTES)) ? 16'(MEM_BYTES) : BYTE_COUNT;
  // Lane of the byte whose read strobe is on the bus this cycle.
  assign w_bus_lane = r_iss[1:0] - 2'd1;
  assign w_cap_done = r_inflt && ((r_rcv[1:0] == 2'd3) || (r_rcv + 16'd1 == r_n));
  assign w_push     = r_word_rdy && !FIFO_FULL;

  // Next-cycle read is blocked while a 4th byte is on the bus, while a word waits on a full FIFO
  // (FIFO_FULL seen now stands in for next cycle), and for the final byte right after a word
  // completes, so that byte can never finish a second word while the first is still held.
  assign w_iss_ok = (r_iss != r_n)
                 && !(r_m_rd && (w_bus_lane == 2'd3))
                 && !(FIFO_FULL && (r_word_rdy || w_cap_done))
                 && !(w_cap_done && (r_iss + 16'd1 == r_n));

  // Little-endian packing; lane 0 starts a fresh word so unused upper bytes read as zero.
  always_comb begin
    w_asm_nx = (r_rcv[1:0] == 2'd0) ? 32'd0 : r_asm;
    w_asm_nx[8*r_rcv[1:0] +: 8] = M_DATA_IN;
  end

  // Control FSM with registered bus strobes, status flags and word datapath.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= 16'd0;
      r_m_add    <= '0;
      r_m_rd     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_fifo_dat <= 32'd0;
      r_asm      <= 32'd0;
      r_word_rdy <= 1'b0;
      r_n        <= 16'd0;
      r_iss      <= 16'd0;
      r_rcv      <= 16'd0;
      r_inflt    <= 1'b0;
      r_poll_cnt <= 16'd0;
      r_wait     <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_n        <= w_n_clamp;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= 16'd0;
            r_busy     <= 1'b1;
            r_poll_cnt <= 16'd0;
            r_iss      <= 16'd0;
            r_rcv      <= 16'd0;
            r_inflt    <= 1'b0;
            r_word_rdy <= 1'b0;
            r_m_add    <= LP_STAT_ADD;
            if (START_REC) begin
              r_m_wr  <= 1'b1;
              r_state <= ST_ARM;
            end else begin
              r_m_rd  <= 1'b1;
              r_state <= ST_POLL;
            end
          end
        end
        ST_ARM: begin
          r_m_wr  <= 1'b0;
          r_m_rd  <= 1'b1;
          r_m_add <= LP_STAT_ADD;
          r_state <= ST_POLL;
        end
        ST_POLL: begin
          r_m_rd  <= 1'b0;
          r_state <= ST_POLL_CHK;
        end
        ST_POLL_CHK: begin
          if (M_DATA_IN[0]) begin
            if (r_n == 16'd0) begin
              r_state <= ST_FLUSH;
            end else begin
              r_m_rd  <= 1'b1;
              r_m_add <= LP_MEM_ADD;
              r_iss   <= 16'd1;
              r_state <= ST_READ;
            end
          end else begin
            r_poll_cnt <= r_poll_cnt + 16'd1;
            if ({1'b0, r_poll_cnt} + 17'd1 == LP_TMO) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_wait  <= LP_WAIT_LD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait == 16'd0) begin
            r_m_rd  <= 1'b1;
            r_m_add <= LP_STAT_ADD;
            r_state <= ST_POLL;
          end else begin
            r_wait <= r_wait - 16'd1;
          end
        end
        ST_READ: begin
          r_inflt <= r_m_rd;
          if (r_inflt) begin
            r_asm <= w_asm_nx;
            r_rcv <= r_rcv + 16'd1;
          end
          if (w_push) begin
            r_word_rdy <= 1'b0;
            r_word_cnt <= r_word_cnt + 16'd1;
          end
          if (w_cap_done) begin
            r_word_rdy <= 1'b1;
            r_fifo_dat <= w_asm_nx;
          end
          r_m_rd <= w_iss_ok;
          if (w_iss_ok) begin
            r_m_add <= LP_MEM_ADD + ABUSWIDTH'(r_iss);
            r_iss   <= r_iss + 16'd1;
          end
          // The last word goes out only after every byte is in, so this push ends the run.
          if (w_push && (r_rcv == r_n)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERR        = r_err;
  assign WORD_CNT   = r_word_cnt;
  assign M_ADD      = r_m_add;
  assign M_RD       = r_m_rd;
  assign M_WR       = r_m_wr;
  assign M_DATA_OUT = 8'h00;
  assign FIFO_DATA  = r_fifo_dat;
  // Gated with the live FIFO_FULL so a push can never coincide with a full FIFO.
  assign FIFO_WRITE = w_push;

endmodule

// File: doc/seq_rec_readout.md
Name: seq_rec_readout

Overview:
Bus-master readout stage that sits directly downstream of the sequence recorder on the BUS_CLK domain. On command it optionally starts a recording and polls the recorder DONE flag. It then reads the recorded bytes over the recorder's slave bus, packs them into 32-bit words and pushes them into the standard FIFO write interface toward the host/SiTCP path. This removes per-byte host polling of recorder memory.

Parameters:
ABUSWIDTH, 16, width of master bus address
REC_BASEADDR, 0, recorder base address on master bus
MEM_BYTES, 8192, recorder memory size; upper clamp for BYTE_COUNT
POLL_INTERVAL, 16, idle BUS_CLK cycles between DONE polls
POLL_TIMEOUT, 65535, maximum number of DONE polls before error

Ports:
BUS_CLK  in  1  clock; all logic in this domain
RST  in  1  synchronous active-high reset
START  in  1  single-cycle command pulse
START_REC  in  1  sampled with START; 1 = issue recorder start write first
BYTE_COUNT  in  16  bytes to read, sampled with START
BUSY  out  1  high from START acceptance until DONE
DONE  out  1  sticky; set at completion, cleared by next accepted START
ERR  out  1  sticky timeout flag; cleared by next accepted START
WORD_CNT  out  16  words pushed in the current/last run
M_ADD  out  ABUSWIDTH  master address
M_RD  out  1  master read strobe
M_WR  out  1  master write strobe
M_DATA_OUT  out  8  master write data
M_DATA_IN  in  8  slave read data, valid the cycle after M_RD
FIFO_FULL  in  1  downstream backpressure
FIFO_WRITE  out  1  word push strobe
FIFO_DATA  out  32  packed word

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR=0, WORD_CNT=0, M_RD=0, M_WR=0, M_ADD=0, M_DATA_OUT=0, FIFO_WRITE=0, FIFO_DATA=0. FSM returns to IDLE.
- RST mid-run: drop any partial or pending word. No further bus or FIFO strobes are issued.
- START is accepted only in IDLE; it is ignored while BUSY. On acceptance: latch N = min(BYTE_COUNT, MEM_BYTES); clear DONE, ERR and WORD_CNT; set BUSY.
- FSM states: IDLE -> ARM (only if START_REC) -> POLL -> POLL_CHK -> WAIT -> READ -> FLUSH -> IDLE.
- ARM: one cycle with M_WR=1, M_ADD=REC_BASEADDR+1, M_DATA_OUT=0. Next cycle go to POLL.
- POLL: one cycle with M_RD=1, M_ADD=REC_BASEADDR+1.
- POLL_CHK: sample M_DATA_IN[0].
  - If 1: go to READ, or to FLUSH if N=0.
  - If 0: increment the poll counter; if it reaches POLL_TIMEOUT, set ERR and DONE, clear BUSY and go to IDLE; otherwise go to WAIT.
- WAIT: POLL_INTERVAL cycles with no strobes, then go to POLL.
- READ: byte index i runs 0..N-1. A read issues M_RD=1 with M_ADD=REC_BASEADDR+16+i.
  - Data returns the next cycle and is packed little-endian: byte i goes to FIFO_DATA[8*(i%4)+7 : 8*(i%4)].
  - At most one read is in flight.
  - No read is issued while the 4th byte of a word is in flight, or while a completed word awaits FIFO space.
  - Steady-state throughput is therefore 4 bytes per 5 cycles when FIFO_FULL=0.
- Word push: a word completes when byte (i%4)=3 arrives.
  - If FIFO_FULL=0, FIFO_WRITE=1 for one cycle in the cycle after completion.
  - Otherwise hold FIFO_DATA stable and assert FIFO_WRITE in the first cycle with FIFO_FULL=0.
  - FIFO_WRITE is never high while FIFO_FULL=1.
  - WORD_CNT increments with each push.
- Last byte (i=N-1) with N%4≠0: the word is pushed with unused upper bytes zero.
- FLUSH: entered after the last push completes (or directly when N=0). Set DONE, clear BUSY, go to IDLE.
- M_ADD arithmetic is modulo 2^ABUSWIDTH. M_RD and M_WR are never high in the same cycle.
- M_ADD holds its last value when no strobe is active.

Test Plan:
- START, START_REC=1, BYTE_COUNT=8; recorder DONE reads 0 twice, then 1; bytes 0x01..0x08 -> one M_WR to base+1, three polls spaced POLL_INTERVAL apart, reads to base+16..base+23, FIFO words 0x04030201 and 0x08070605, WORD_CNT=2, DONE=1, BUSY=0.
- BYTE_COUNT=5, START_REC=0, bytes 0xA0..0xA4 -> no M_WR, words 0xA3A2A1A0 and 0x000000A4, WORD_CNT=2.
- BYTE_COUNT=12 with FIFO_FULL held high for 10 cycles at the first word completion -> FIFO_DATA stable throughout, no reads issued during the stall, three correct words in order, no FIFO_WRITE while full.
- DONE flag never set, POLL_TIMEOUT=4 -> exactly 4 polls, then ERR=1, DONE=1, WORD_CNT=0, no reads of memory space.
- BYTE_COUNT=0 -> polls until DONE, then DONE=1 with no memory reads and no FIFO_WRITE. BYTE_COUNT=0xFFFF with MEM_BYTES=8192 -> exactly 8192 reads, 2048 words.
- RST asserted mid-READ, then a new START with BYTE_COUNT=4 -> all outputs at reset values after RST, no partial word pushed, second run produces exactly one correct word.
